// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding imem requester feeding a small FIFO
// of {pc, instr} entries, with redirect flush and discard of stale responses.
module fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  input  logic        ir_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // S_IDLE: nothing outstanding; S_WAIT: response kept; S_DROP: response discarded
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   q_pc_q [DEPTH];
  logic [15:0]   q_ir_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, count_after;
  logic          push, pop, space, free;

  assign ir_valid  = (count_q != '0);
  assign ir        = q_ir_q[rd_ptr_q];
  assign ir_pc     = q_pc_q[rd_ptr_q];
  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;

  always_comb begin
    pop         = ir_valid && ir_ready && !redirect;
    push        = imem_ack && (state_q == S_WAIT) && !redirect;
    count_after = count_q + CW'(push) - CW'(pop);
    space       = (count_after < CW'(DEPTH));
    // A stray ack in S_IDLE is harmless here: free is already true and push stays low.
    free        = (state_q == S_IDLE) || imem_ack;
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    count_d     = count_after;
    if (redirect) begin
      count_d    = '0;
      fetch_pc_d = redirect_pc & 16'hFFFE;
      state_d    = ((state_q != S_IDLE) && !imem_ack) ? S_DROP : S_IDLE;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 16'd2;
      if (free) begin
        state_d = space ? S_WAIT : S_IDLE;
        if (space) addr_d = fetch_pc_d;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i] <= '0;
        q_ir_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          q_pc_q[wr_ptr_q] <= fetch_pc_q;
          q_ir_q[wr_ptr_q] <= imem_rdata;
          wr_ptr_q         <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  a_ack_needs_request: assert property (@(posedge clock) disable iff (reset)
    imem_ack |-> (state_q != S_IDLE));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a
// queue-based reference model and a variable-latency memory responder.
module tb_fetch_queue;
  localparam int DEPTH = 2;

  logic        clock = 1'b0, reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr, imem_rdata = 16'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        ir_valid, ir_ready = 1'b0;
  logic [15:0] ir, ir_pc;

  logic        imem_req2, imem_ack2 = 1'b0;
  logic [15:0] imem_addr2, imem_rdata2 = 16'h0;
  logic        redirect2 = 1'b0;
  logic [15:0] redirect_pc2 = 16'h0;
  logic        ir_valid2, ir_ready2 = 1'b0;
  logic [15:0] ir2, ir_pc2;

  int          nchk = 0, nfail = 0;
  logic [15:0] mem [0:65535];
  int          mem_lat = 1, age = 0, cur_lat = 0;
  bit          mem_rand = 1'b0;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
    .ir_ready(ir_ready));

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) dut2 (
    .clock(clock), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .ir_valid(ir_valid2), .ir(ir2), .ir_pc(ir_pc2),
    .ir_ready(ir_ready2));

  // Memory for dut: acks a request after mem_lat (or random 0..3) extra cycles.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      imem_ack = 1'b0; age = 0;
    end else if (imem_req) begin
      if (age == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      if (age >= cur_lat) begin
        imem_ack = 1'b1; imem_rdata = mem[imem_addr]; age = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = 16'($urandom); age++;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom); age = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; redirect = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    nchk++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    nchk++; if (imem_addr !== 16'h0000) begin nfail++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    nchk++; if (ir_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    nchk++; if (ir !== 16'h0000) begin nfail++; $display("FAIL reset_ir: got %h want 0000", ir); end
    nchk++; if (ir_pc !== 16'h0000) begin nfail++; $display("FAIL reset_ir_pc: got %h want 0000", ir_pc); end
    nchk++; if (imem_addr2 !== 16'hFFFC) begin nfail++; $display("FAIL reset_addr2: got %h want fffc", imem_addr2); end
    @(posedge clock); #1;
    nchk++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL reset_held_req: got %b want 0", imem_req); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic_stream();
    int first_req = -1, first_val = -1, n = 0;
    logic [15:0] gi [3] = '{default: 16'h0};
    logic [15:0] gp [3] = '{default: 16'h0};
    logic [15:0] e_ir [3] = '{16'h5100, 16'h5202, 16'h76C0};
    mem_rand = 1'b0; mem_lat = 1; ir_ready = 1'b1;
    do_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (imem_req && first_req < 0) first_req = cyc;
      if (ir_valid && first_val < 0) first_val = cyc;
      if (ir_valid && ir_ready && n < 3) begin gi[n] = ir; gp[n] = ir_pc; n++; end
    end
    nchk++; if (n != 3) begin nfail++; $display("FAIL basic_count: got %0d pops want 3", n); end
    for (int i = 0; i < 3; i++) begin
      nchk++; if (gi[i] !== e_ir[i]) begin nfail++; $display("FAIL basic_ir[%0d]: got %h want %h", i, gi[i], e_ir[i]); end
      nchk++; if (gp[i] !== 16'(2 * i)) begin nfail++; $display("FAIL basic_pc[%0d]: got %h want %h", i, gp[i], 16'(2 * i)); end
    end
    nchk++; if (first_val - first_req != 2) begin nfail++; $display("FAIL basic_latency: got %0d want 2", first_val - first_req); end
    ir_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    int acks = 0, late = 0, n = 0;
    bit got_addr = 1'b0;
    logic [15:0] first_addr = 16'hFFFF;
    mem_rand = 1'b0; mem_lat = 1; ir_ready = 1'b0;
    do_reset();
    repeat (20) begin
      @(negedge clock);
      if (acks == 2 && imem_req) late++;
      if (imem_ack) acks++;
    end
    nchk++; if (acks != 2) begin nfail++; $display("FAIL full_acks: got %0d want 2", acks); end
    nchk++; if (late != 0) begin nfail++; $display("FAIL full_req_after_full: got %0d cycles want 0", late); end
    nchk++; if (ir_valid !== 1'b1) begin nfail++; $display("FAIL full_valid: got %b want 1", ir_valid); end
    nchk++; if (ir !== 16'h5100) begin nfail++; $display("FAIL full_ir_hold: got %h want 5100", ir); end
    nchk++; if (ir_pc !== 16'h0000) begin nfail++; $display("FAIL full_pc_hold: got %h want 0000", ir_pc); end
    ir_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      if (imem_req && !got_addr) begin first_addr = imem_addr; got_addr = 1'b1; end
      if (ir_valid) begin
        nchk++; if (ir_pc !== 16'(2 * n)) begin nfail++; $display("FAIL resume_pc[%0d]: got %h want %h", n, ir_pc, 16'(2 * n)); end
        nchk++; if (ir !== mem[16'(2 * n)]) begin nfail++; $display("FAIL resume_ir[%0d]: got %h want %h", n, ir, mem[16'(2 * n)]); end
        n++;
      end
      @(negedge clock);
    end
    nchk++; if (n != 4) begin nfail++; $display("FAIL resume_count: got %0d want 4", n); end
    nchk++; if (!got_addr || first_addr !== 16'h0004) begin nfail++; $display("FAIL resume_addr: got %h want 0004", first_addr); end
    ir_ready = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    int six = 0, dead_ack = 0, seen6 = 0;
    bit found = 1'b0, got_addr = 1'b0, got_pop = 1'b0;
    logic [15:0] new_addr = 16'hFFFF, pop_pc = 16'hFFFF, pop_ir = 16'h0;
    mem_rand = 1'b0; mem_lat = 3; ir_ready = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 80 && !found; cyc++) begin
      @(negedge clock);
      if (imem_req && imem_addr == 16'h0006 && !imem_ack) found = 1'b1;
    end
    nchk++; if (!found) begin nfail++; $display("FAIL redir_wait: got no request to 0006 want one within 80 cycles"); end
    redirect = 1'b1; redirect_pc = 16'h0011;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (imem_req && imem_addr == 16'h0006) begin
        six++;
        if (imem_ack) dead_ack++;
      end else if (imem_req && !got_addr) begin
        got_addr = 1'b1; new_addr = imem_addr;
      end
      if (ir_valid && ir_pc == 16'h0006) seen6++;
      if (cyc > 0 && ir_valid && !got_pop) begin got_pop = 1'b1; pop_pc = ir_pc; pop_ir = ir; end
      @(negedge clock);
      if (cyc == 0) begin
        redirect = 1'b0;
        nchk++; if (ir_valid !== 1'b0) begin nfail++; $display("FAIL redir_flush_valid: got %b want 0", ir_valid); end
      end
    end
    nchk++; if (six != 4) begin nfail++; $display("FAIL redir_req_held: got %0d cycles want 4", six); end
    nchk++; if (dead_ack != 1) begin nfail++; $display("FAIL redir_dead_ack: got %0d want 1", dead_ack); end
    nchk++; if (seen6 != 0) begin nfail++; $display("FAIL redir_dead_seen: got %0d cycles want 0", seen6); end
    nchk++; if (new_addr !== 16'h0010) begin nfail++; $display("FAIL redir_new_addr: got %h want 0010", new_addr); end
    nchk++; if (pop_pc !== 16'h0010) begin nfail++; $display("FAIL redir_first_pc: got %h want 0010", pop_pc); end
    nchk++; if (pop_ir !== mem[16'h0010]) begin nfail++; $display("FAIL redir_first_ir: got %h want %h", pop_ir, mem[16'h0010]); end
    ir_ready = 1'b0;
  endtask

  task automatic test_redirect_ack_pop();
    bit found = 1'b0, got_addr = 1'b0, got_pop = 1'b0;
    logic [15:0] new_addr = 16'hFFFF, pop_pc = 16'hFFFF, pop_ir = 16'h0;
    mem_rand = 1'b0; mem_lat = 0; ir_ready = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      @(negedge clock);
      if (imem_ack && ir_valid) found = 1'b1;
    end
    nchk++; if (!found) begin nfail++; $display("FAIL ackpop_wait: got no ack+valid cycle want one within 40"); end
    redirect = 1'b1; redirect_pc = 16'h0101;
    @(negedge clock);
    redirect = 1'b0;
    nchk++; if (ir_valid !== 1'b0) begin nfail++; $display("FAIL ackpop_valid: got %b want 0", ir_valid); end
    nchk++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL ackpop_idle: got req %b want 0", imem_req); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (imem_req && !got_addr) begin got_addr = 1'b1; new_addr = imem_addr; end
      if (ir_valid && !got_pop) begin got_pop = 1'b1; pop_pc = ir_pc; pop_ir = ir; end
      @(negedge clock);
    end
    nchk++; if (new_addr !== 16'h0100) begin nfail++; $display("FAIL ackpop_addr: got %h want 0100", new_addr); end
    nchk++; if (pop_pc !== 16'h0100) begin nfail++; $display("FAIL ackpop_pc: got %h want 0100", pop_pc); end
    nchk++; if (pop_ir !== mem[16'h0100]) begin nfail++; $display("FAIL ackpop_ir: got %h want %h", pop_ir, mem[16'h0100]); end
    ir_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    int n = 0;
    bit got_head = 1'b0;
    logic [15:0] a [3] = '{default: 16'h1111};
    logic [15:0] e_a [3] = '{16'hFFFC, 16'hFFFE, 16'h0000};
    logic [15:0] hpc = 16'h0, hir = 16'h0;
    ir_ready2 = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (ir_valid2 && !got_head) begin got_head = 1'b1; hpc = ir_pc2; hir = ir2; end
      if (imem_req2 && n < 3) begin
        a[n] = imem_addr2; n++;
        imem_ack2 = 1'b1; imem_rdata2 = ~imem_addr2;
      end else begin
        imem_ack2 = 1'b0;
      end
      @(negedge clock);
    end
    imem_ack2 = 1'b0; ir_ready2 = 1'b0;
    nchk++; if (n != 3) begin nfail++; $display("FAIL wrap_count: got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      nchk++; if (a[i] !== e_a[i]) begin nfail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, a[i], e_a[i]); end
    end
    nchk++; if (hpc !== 16'hFFFC) begin nfail++; $display("FAIL wrap_head_pc: got %h want fffc", hpc); end
    nchk++; if (hir !== 16'h0003) begin nfail++; $display("FAIL wrap_head_ir: got %h want 0003", hir); end
  endtask

  task automatic test_reset_midflight();
    bit found = 1'b0, got_addr = 1'b0, got_pop = 1'b0;
    logic [15:0] new_addr = 16'hFFFF, pop_pc = 16'hFFFF, pop_ir = 16'h0;
    mem_rand = 1'b0; mem_lat = 3; ir_ready = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      @(negedge clock);
      if (ir_valid && imem_req) found = 1'b1;
    end
    nchk++; if (!found) begin nfail++; $display("FAIL midrst_wait: got no valid+req cycle want one within 40"); end
    #2 reset = 1'b1;
    #1;
    nchk++; if (imem_req !== 1'b0) begin nfail++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    nchk++; if (imem_addr !== 16'h0000) begin nfail++; $display("FAIL midrst_addr: got %h want 0000", imem_addr); end
    nchk++; if (ir_valid !== 1'b0) begin nfail++; $display("FAIL midrst_valid: got %b want 0", ir_valid); end
    nchk++; if (ir !== 16'h0000) begin nfail++; $display("FAIL midrst_ir: got %h want 0000", ir); end
    nchk++; if (ir_pc !== 16'h0000) begin nfail++; $display("FAIL midrst_ir_pc: got %h want 0000", ir_pc); end
    @(negedge clock);
    reset = 1'b0; ir_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (imem_req && !got_addr) begin got_addr = 1'b1; new_addr = imem_addr; end
      if (ir_valid && !got_pop) begin got_pop = 1'b1; pop_pc = ir_pc; pop_ir = ir; end
      @(negedge clock);
    end
    nchk++; if (new_addr !== 16'h0000) begin nfail++; $display("FAIL midrst_first_addr: got %h want 0000", new_addr); end
    nchk++; if (pop_pc !== 16'h0000 || pop_ir !== 16'h5100) begin nfail++; $display("FAIL midrst_first_ir: got %h@%h want 5100@0000", pop_ir, pop_pc); end
    ir_ready = 1'b0;
  endtask

  // Reference model: the queue holds the pcs of kept responses in order; the fetch pc
  // advances by 2 per kept response and jumps on redirect; a request outstanding at a
  // redirect is dropped; a new request is presented whenever nothing is outstanding,
  // no redirect occurred, and the queue has room after this cycle's push/pop.
  task automatic test_random();
    logic [15:0] pcq [$];
    logic [15:0] fpc, req_addr, rpc;
    bit exp_req, new_req, keep, rd, rdy, ack, pop, push, out_after;
    mem_rand = 1'b1; ir_ready = 1'b0;
    do_reset();
    fpc = 16'h0000; req_addr = 16'h0000;
    exp_req = 1'b0; new_req = 1'b1; keep = 1'b0;
    for (int cyc = 0; cyc < 3000 && nfail < 30; cyc++) begin
      nchk++; if (ir_valid !== (pcq.size() != 0)) begin nfail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, ir_valid, pcq.size() != 0); end
      if (pcq.size() != 0) begin
        nchk++; if (ir_pc !== pcq[0]) begin nfail++; $display("FAIL rnd_ir_pc @%0d: got %h want %h", cyc, ir_pc, pcq[0]); end
        nchk++; if (ir !== mem[pcq[0]]) begin nfail++; $display("FAIL rnd_ir @%0d: got %h want %h", cyc, ir, mem[pcq[0]]); end
      end
      nchk++; if (imem_req !== exp_req) begin nfail++; $display("FAIL rnd_req @%0d: got %b want %b", cyc, imem_req, exp_req); end
      if (exp_req) begin
        if (new_req) begin
          nchk++; if (imem_addr !== fpc) begin nfail++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, imem_addr, fpc); end
          req_addr = fpc; keep = 1'b1;
        end else begin
          nchk++; if (imem_addr !== req_addr) begin nfail++; $display("FAIL rnd_addr_stable @%0d: got %h want %h", cyc, imem_addr, req_addr); end
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 24) == 0);
      rpc = 16'($urandom);
      ir_ready = rdy; redirect = rd; redirect_pc = rpc;
      ack  = imem_ack && exp_req;
      pop  = (pcq.size() != 0) && rdy;
      push = ack && keep && !rd;
      if (rd) begin
        pcq.delete();
        fpc = rpc & 16'hFFFE;
        if (exp_req && !ack) keep = 1'b0;
      end else begin
        if (pop) void'(pcq.pop_front());
        if (push) begin pcq.push_back(fpc); fpc = fpc + 16'd2; end
      end
      out_after = exp_req && !ack;
      exp_req   = out_after ? 1'b1 : (!rd && pcq.size() < DEPTH);
      new_req   = !out_after;
      @(negedge clock);
      redirect = 1'b0;
    end
    ir_ready = 1'b0; mem_rand = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5A3C;
    mem[16'h0000] = 16'h5100;
    mem[16'h0002] = 16'h5202;
    mem[16'h0004] = 16'h76C0;
    test_reset();
    test_basic_stream();
    test_full_stall();
    mem[16'h0006] = 16'hDEAD;
    test_redirect_outstanding();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle CPU's decode/execute path.
- Owns the fetch PC and issues 16-bit instruction reads to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them to the consumer with valid/ready.
- Accepts redirects (taken branch/jump) from downstream, which flush the queue and restart fetch at the new target.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, 2..8).
- RESET_PC, 16'h0000, fetch PC after reset (bit 0 must be 0).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  16  byte address of the request; always even.
- imem_ack  in  1  one-cycle pulse: imem_rdata is valid and the request is complete.
- imem_rdata  in  16  instruction word returned with imem_ack.
- redirect  in  1  one-cycle pulse: flush the queue and restart fetch.
- redirect_pc  in  16  new fetch target; bit 0 is ignored and forced to 0.
- ir_valid  out  1  queue head holds a valid instruction.
- ir  out  16  instruction at the queue head.
- ir_pc  out  16  byte address of the queue head instruction.
- ir_ready  in  1  consumer accepts the head this cycle when ir_valid is also high.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DROP: request outstanding; its response will be discarded.
- At most one request is outstanding at any time.
- Issue from IDLE when count + (push this cycle) - (pop this cycle) < DEPTH, and no redirect this cycle:
  - Next cycle imem_req=1 and imem_addr=fetch_pc; go to WAIT.
  - imem_req and imem_addr stay stable until the cycle imem_ack=1.
  - imem_req drops the cycle after the ack unless a back-to-back issue is allowed.
- Back-to-back issue: in the WAIT ack cycle, if space remains after the push, the next request (fetch_pc+2) is presented the following cycle.
  - Sustained throughput is one instruction per cycle when the memory acks every cycle.
- Ack in WAIT:
  - Push {fetch_pc, imem_rdata} into the queue.
  - fetch_pc <= fetch_pc + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Ack in DROP: discard the data, leave fetch_pc unchanged, go to IDLE (or issue immediately per the space rule).
- A request is never withdrawn: imem_req stays high until ack, even across redirects.
- Redirect (has priority over every other event in the same cycle):
  - Queue emptied; any same-cycle pop and push are cancelled.
  - fetch_pc <= {redirect_pc[15:1],1'b0}.
  - Outstanding request with no ack this cycle: state -> DROP.
  - Ack in the same cycle as the redirect: data discarded, state -> IDLE.
  - ir_valid=0 the cycle after a redirect.
- Redirect while already in DROP: update fetch_pc only; stay in DROP.
- Output side:
  - ir_valid = (count != 0); ir/ir_pc show the head entry, registered queue storage, no combinational path from imem_rdata.
  - Minimum latency from ack to ir_valid is 1 cycle.
  - Pop when ir_valid && ir_ready.
  - Pop and push in the same cycle: count unchanged, order preserved.
- Full: no issue while count == DEPTH, except when a pop this cycle frees a slot.
- Empty: ir_ready is ignored.
- Overflow cannot occur by construction. Flag an ack with no outstanding request as an assertion error and ignore the data.
- Reset mid-transaction: all state clears immediately and imem_req=0. The memory must tolerate an abandoned request.

Test Plan:
- Reset, memory acks 1 cycle after req, ir_ready=1, memory returns 16'h5100,16'h5202,16'h76C0 -> ir/ir_pc sequence (5100,0000),(5202,0002),(76C0,0004); ir_valid first high 2 cycles after first ack-ready request.
- ir_ready=0 with DEPTH=2 -> exactly 2 acks accepted, imem_req stays 0 afterward, ir holds 16'h5100. Raise ir_ready -> fetch resumes at 16'h0004 with no lost or duplicated words.
- Redirect to 16'h0011 while a request to 16'h0006 is outstanding (ack 3 cycles later with 16'hDEAD) -> queue flushed, DEAD never appears on ir, next request addr=16'h0010.
- Redirect in the same cycle as an ack and a pop -> data dropped, ir_valid=0 next cycle, next imem_addr = redirect target.
- RESET_PC=16'hFFFC, 3 fetches -> addresses FFFC, FFFE, 0000.
- Assert reset while imem_req=1 and the queue holds 1 entry -> outputs return to reset values asynchronously; after release the first request is at RESET_PC.
